// File: rtl/shift_seq_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_pkg : opcodes, FSM state encoding and width helper for shift_seq_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package shift_seq_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_CLEAR = 3'd2;
  localparam logic [2:0] OP_SHL   = 3'd3;
  localparam logic [2:0] OP_SHR   = 3'd4;
  localparam logic [2:0] OP_ASR   = 3'd5;
  localparam logic [2:0] OP_ROL   = 3'd6;
  localparam logic [2:0] OP_ROR   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Width of the shift-amount field; never narrower than one bit
  function automatic int amt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_seq_step.sv
// ---------------------------------------------------------------------------
// shift_seq_step : combinational single-bit step for SHL/SHR/ASR/ROL/ROR
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_seq_step
  import shift_seq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] i_data,
  input  logic [2:0]   i_op,
  input  logic         i_fill,
  output logic [N-1:0] o_data,
  output logic         o_carry
);

  always_comb begin
    o_data  = i_data;
    o_carry = 1'b0;
    case (i_op)
      OP_SHL: begin
        o_data  = {i_data[N-2:0], i_fill};
        o_carry = i_data[N-1];
      end
      OP_SHR: begin
        o_data  = {i_fill, i_data[N-1:1]};
        o_carry = i_data[0];
      end
      OP_ASR: begin
        o_data  = {i_data[N-1], i_data[N-1:1]};
        o_carry = i_data[0];
      end
      OP_ROL: begin
        o_data  = {i_data[N-2:0], i_data[N-1]};
        o_carry = i_data[N-1];
      end
      OP_ROR: begin
        o_data  = {i_data[0], i_data[N-1:1]};
        o_carry = i_data[0];
      end
      default: begin
        o_data  = i_data;
        o_carry = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_seq_unit.sv
// ---------------------------------------------------------------------------
// shift_seq_unit : command-driven multi-cycle shifter with valid/ready and done.
// Optional macro SHIFT_SEQ_UNIT_SERIAL_IN_EN adds i_serial_in as SHL/SHR fill.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module shift_seq_unit
  import shift_seq_pkg::*;
#(
  parameter int N     = 8,
  parameter int AMT_W = amt_width(N)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ce,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [AMT_W-1:0] i_cmd_amt,
  input  logic [N-1:0]     i_data,
`ifdef SHIFT_SEQ_UNIT_SERIAL_IN_EN
  input  logic             i_serial_in,
`endif
  output logic [N-1:0]     o_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_carry
);

  state_t           r_state;
  state_t           w_state_next;
  logic [AMT_W-1:0] r_count;
  logic [AMT_W-1:0] w_count_next;
  logic [2:0]       r_op;
  logic [2:0]       w_op_next;
  logic [N-1:0]     r_data;
  logic [N-1:0]     w_data_next;
  logic             r_carry;
  logic             w_carry_next;
  logic             w_accept;
  logic             w_fill;
  logic [N-1:0]     w_step_data;
  logic             w_step_carry;

`ifdef SHIFT_SEQ_UNIT_SERIAL_IN_EN
  assign w_fill = i_serial_in;
`else
  assign w_fill = 1'b0;
`endif

  shift_seq_step #(
    .N (N)
  ) u_step (
    .i_data  (r_data),
    .i_op    (r_op),
    .i_fill  (w_fill),
    .o_data  (w_step_data),
    .o_carry (w_step_carry)
  );

  assign w_accept = i_cmd_valid && (r_state == ST_IDLE);

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_op_next    = r_op;
    w_data_next  = r_data;
    w_carry_next = r_carry;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_op_next    = i_cmd_op;
          w_state_next = ST_DONE;
          case (i_cmd_op)
            OP_NOP: ;
            OP_LOAD: begin
              w_data_next  = i_data;
              w_carry_next = 1'b0;
            end
            OP_CLEAR: begin
              w_data_next  = '0;
              w_carry_next = 1'b0;
            end
            default: begin
              // Zero-length shifts complete immediately with carry untouched
              if (i_cmd_amt != '0) begin
                w_state_next = ST_SHIFT;
                w_count_next = i_cmd_amt;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        w_data_next  = w_step_data;
        w_carry_next = w_step_carry;
        w_count_next = r_count - 1'b1;
        if (r_count == AMT_W'(1)) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_op    <= OP_NOP;
      r_data  <= '0;
      r_carry <= 1'b0;
    end else if (i_ce) begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_op    <= w_op_next;
      r_data  <= w_data_next;
      r_carry <= w_carry_next;
    end
  end

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign o_busy      = (r_state == ST_SHIFT);
  assign o_done      = (r_state == ST_DONE);
  assign o_data      = r_data;
  assign o_carry     = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_unit : directed vector table plus hand sequences for shift_seq_unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_shift_seq_unit;

  localparam int N     = 8;
  localparam int AMT_W = 3;

  logic             clk;
  logic             rst;
  logic             ce;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [N-1:0]     din;
  logic [N-1:0]     dout;
  logic             busy;
  logic             done;
  logic             carry;
`ifdef SHIFT_SEQ_UNIT_SERIAL_IN_EN
  logic             serial_in;
`endif

  shift_seq_unit #(
    .N     (N),
    .AMT_W (AMT_W)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_ce        (ce),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_amt   (cmd_amt),
    .i_data      (din),
`ifdef SHIFT_SEQ_UNIT_SERIAL_IN_EN
    .i_serial_in (serial_in),
`endif
    .o_data      (dout),
    .o_busy      (busy),
    .o_done      (done),
    .o_carry     (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic [7:0]       din;
    logic [7:0]       exp_data;
    logic             exp_carry;
    int               exp_lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE, measure accept-to-done latency, check results
  task automatic run_cmd(input int idx, input logic [2:0] op, input logic [AMT_W-1:0] amt,
                         input logic [7:0] d, input logic [7:0] exp_d, input logic exp_c,
                         input int exp_lat);
    int lat;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_amt   = amt;
    din       = d;
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check($sformatf("v%0d latency", idx), lat, exp_lat);
    check($sformatf("v%0d data", idx), dout, exp_d);
    check($sformatf("v%0d carry", idx), carry, exp_c);
    tick();
    check($sformatf("v%0d done_pulse_ready", idx), {done, cmd_ready}, 2'b01);
  endtask

  initial begin
    rst = 1'b1;
    ce = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_amt = '0;
    din = '0;
`ifdef SHIFT_SEQ_UNIT_SERIAL_IN_EN
    serial_in = 1'b0;
`endif
    tick();
    tick();
    check("reset data", dout, 8'h00);
    check("reset flags", {carry, busy, done, cmd_ready}, 4'b0001);
    rst = 1'b0;
    tick();

    //         op    amt  din    data   c  lat
    vecs[0]  = '{3'd1, 3'd0, 8'hA5, 8'hA5, 1'b0, 1};
    vecs[1]  = '{3'd1, 3'd0, 8'h81, 8'h81, 1'b0, 1};
    vecs[2]  = '{3'd6, 3'd3, 8'h00, 8'h0C, 1'b0, 4};
    vecs[3]  = '{3'd1, 3'd0, 8'h90, 8'h90, 1'b0, 1};
    vecs[4]  = '{3'd5, 3'd2, 8'h00, 8'hE4, 1'b0, 3};
    vecs[5]  = '{3'd4, 3'd0, 8'h00, 8'hE4, 1'b0, 1};
    vecs[6]  = '{3'd4, 3'd3, 8'h00, 8'h1C, 1'b1, 4};
    vecs[7]  = '{3'd0, 3'd0, 8'h55, 8'h1C, 1'b1, 1};
    vecs[8]  = '{3'd7, 3'd1, 8'h00, 8'h0E, 1'b0, 2};
    vecs[9]  = '{3'd1, 3'd0, 8'h01, 8'h01, 1'b0, 1};
    vecs[10] = '{3'd7, 3'd1, 8'h00, 8'h80, 1'b1, 2};
    vecs[11] = '{3'd1, 3'd0, 8'hFF, 8'hFF, 1'b0, 1};
    vecs[12] = '{3'd3, 3'd7, 8'h00, 8'h80, 1'b1, 8};
    vecs[13] = '{3'd2, 3'd0, 8'h77, 8'h00, 1'b0, 1};
    vecs[14] = '{3'd1, 3'd0, 8'h5A, 8'h5A, 1'b0, 1};
    vecs[15] = '{3'd6, 3'd7, 8'h00, 8'h2D, 1'b1, 8};

    for (int i = 0; i < 16; i++) begin
      run_cmd(i, vecs[i].op, vecs[i].amt, vecs[i].din,
              vecs[i].exp_data, vecs[i].exp_carry, vecs[i].exp_lat);
    end

    // ROL intermediate values
    run_cmd(100, 3'd1, 3'd0, 8'h81, 8'h81, 1'b0, 1);
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_amt = 3'd3;
    tick();
    cmd_valid = 1'b0;
    check("rol accept busy", {busy, cmd_ready, dout}, {2'b10, 8'h81});
    tick();
    check("rol step1", {busy, dout}, {1'b1, 8'h03});
    tick();
    check("rol step2", {busy, dout}, {1'b1, 8'h06});
    tick();
    check("rol step3", {busy, done, carry, dout}, {3'b010, 8'h0C});
    tick();

    // Stall mid-shift while a LOAD waits on a busy unit
    run_cmd(101, 3'd1, 3'd0, 8'hFF, 8'hFF, 1'b0, 1);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_amt = 3'd5;
    tick();
    cmd_op = 3'd1; din = 8'h3C;
    tick();
    tick();
    check("stall pre", dout, 8'hFC);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall hold", {busy, cmd_ready, dout}, {2'b10, 8'hFC});
    end
    ce = 1'b1;
    tick();
    tick();
    tick();
    check("stall final", {done, carry, cmd_ready, dout}, {3'b110, 8'hE0});
    tick();
    check("stall idle no accept", {done, cmd_ready, dout}, {2'b01, 8'hE0});
    tick();
    check("stall pending load", {done, dout}, {1'b1, 8'h3C});
    cmd_valid = 1'b0;
    tick();

    // Stalled DONE keeps o_done high
    run_cmd(102, 3'd1, 3'd0, 8'h11, 8'h11, 1'b0, 1);
    cmd_valid = 1'b1; cmd_op = 3'd2;
    tick();
    cmd_valid = 1'b0;
    ce = 1'b0;
    tick();
    tick();
    check("done held", {done, dout}, {1'b1, 8'h00});
    ce = 1'b1;
    tick();
    check("done release", {done, cmd_ready}, 2'b01);

    // Reset aborts an in-flight shift
    run_cmd(103, 3'd1, 3'd0, 8'hFF, 8'hFF, 1'b0, 1);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_amt = 3'd5;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("abort pre", {carry, dout}, {1'b1, 8'hFC});
    rst = 1'b1;
    tick();
    check("abort reset", {carry, busy, done, cmd_ready, dout}, {4'b0001, 8'h00});
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort no done", {done, cmd_ready}, 2'b01);
    end

`ifdef SHIFT_SEQ_UNIT_SERIAL_IN_EN
    run_cmd(104, 3'd1, 3'd0, 8'h00, 8'h00, 1'b0, 1);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_amt = 3'd4;
    serial_in = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    serial_in = 1'b0;
    tick();
    serial_in = 1'b1;
    tick();
    tick();
    check("serial shl", {done, dout}, {1'b1, 8'h0B});
    serial_in = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_seq_unit.md
Name: shift_seq_unit

Overview:
- Multi-cycle, command-driven shift engine; parametrised successor of the basic load/shift register.
- Adds logical, arithmetic and rotate modes, programmable shift amount, a carry-out bit, a valid/ready command handshake and a done pulse.
- Sits on the emulator datapath wherever a small sequential shifter is needed, e.g. CPU shift ops or bit-serial peripherals.

Parameters:
- N, 8, data width in bits; N >= 2.
- AMT_W, $clog2(N), width of the shift-amount field; amounts 0..2^AMT_W-1 are legal.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset; clock i_clk.
- i_ce  in  1  clock enable; when low, all state (including o_done) holds.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  high only in IDLE.
- i_cmd_op  in  3  opcode: 0 NOP, 1 LOAD, 2 CLEAR, 3 SHL, 4 SHR, 5 ASR, 6 ROL, 7 ROR.
- i_cmd_amt  in  AMT_W  shift count; ignored for ops 0-2.
- i_data  in  N  load value; used by LOAD only.
- o_data  out  N  register contents.
- o_busy  out  1  high in SHIFT state.
- o_done  out  1  one-cycle pulse marking command completion.
- o_carry  out  1  last bit shifted or rotated out.

Behaviour:
- Reset has priority over i_ce and forces:
  - o_data = 0, o_carry = 0, state IDLE, o_busy = 0, o_done = 0, o_cmd_ready = 1.
  - Reset during SHIFT aborts the command; no o_done is produced.
- Accept edge: rising i_clk with i_ce & i_cmd_valid & o_cmd_ready. Op, amount and i_data are captured there.
- i_cmd_valid while not ready is ignored, not queued.
- States: IDLE, SHIFT, DONE.
- From IDLE on accept:
  - LOAD: o_data <= i_data, o_carry <= 0, go to DONE.
  - CLEAR: o_data <= 0, o_carry <= 0, go to DONE.
  - NOP: no change, go to DONE.
  - Shift op with amt = 0: no change (carry kept), go to DONE.
  - Shift op with amt = k > 0: go to SHIFT with remaining-count register = k.
- SHIFT: exactly one 1-bit step per i_ce-qualified edge; count decrements each step; after the k-th step, go to DONE.
- Step rules:
  - SHL: data << 1, fill 0, carry = old MSB.
  - SHR: data >> 1, fill 0, carry = old LSB.
  - ASR: fill with old MSB, carry = old LSB.
  - ROL: old MSB goes to LSB, carry = old MSB.
  - ROR: old LSB goes to MSB, carry = old LSB.
- DONE: o_done = 1 for the cycle; next i_ce edge returns to IDLE.
- Latency: o_done is high in the cycle following the last data update.
  - Single-cycle ops: done in the cycle after accept.
  - Shift by k: o_done high k+1 cycles after accept when i_ce is held high.
- i_ce low in any state freezes state, count, o_data, o_carry and o_done. A stalled DONE keeps o_done high until the next enabled edge.
- Amount >= N is legal and steps the full count. Example: SHL by 9 with N = 8 yields 0, carry 0.
- o_data changes only on reset, LOAD, CLEAR or shift steps.

Optional Feature:
- Macro: SHIFT_SEQ_UNIT_SERIAL_IN_EN.
- Defined:
  - Adds input port i_serial_in (1 bit).
  - SHL fills the LSB and SHR fills the MSB with i_serial_in, sampled on each step edge.
  - Other ops unchanged.
- Undefined: port absent; SHL/SHR fill with 0.

Decomposition:
- Package shift_seq_pkg holds:
  - opcode localparams OP_NOP .. OP_ROR (3 bits);
  - state encoding ST_IDLE, ST_SHIFT, ST_DONE;
  - helper function computing the default AMT_W.
- One combinational sub-module, shift_seq_step:
  - inputs: data, op, fill bit;
  - outputs: next data, carry-out;
  - implements a single 1-bit step for all five shift ops.
- The top level holds the FSM, count register, handshake and data/carry registers.

Test Plan (N = 8):
- Reset, then LOAD 0xA5 → o_data = 0xA5 after the accept edge; o_done pulses 1 cycle; o_carry = 0; o_cmd_ready returns high.
- LOAD 0x81, then ROL amt 3 → o_busy high 3 cycles; intermediate values 0x03, 0x06, 0x0C; final o_data = 0x0C, o_carry = 0; o_done 4 cycles after accept.
- LOAD 0x90, then ASR amt 2 → o_data = 0xE4, o_carry = 0. Then SHR amt 0 → o_data stays 0xE4, o_done in the next cycle.
- LOAD 0xFF, SHL amt 5; i_ce low for 3 cycles after the 2nd step; i_cmd_valid held high with a LOAD throughout:
  - o_data frozen at 0xFC during the stall;
  - final o_data = 0xE0, o_carry = 1;
  - the pending LOAD is accepted only after DONE→IDLE.
- LOAD 0xFF, SHL amt 5; assert i_reset after 2 steps → o_data = 0, o_carry = 0, IDLE, no o_done pulse.
- With SHIFT_SEQ_UNIT_SERIAL_IN_EN: LOAD 0x00, SHL amt 4 with i_serial_in = 1,0,1,1 → o_data = 0x0B.
